// File: rtl/pcie_msg_pkg.sv
// rtl/pcie_msg_pkg.sv - shared constants and types for the message queue controller
package pcie_msg_pkg;

    localparam int NUM_Q         = 15;
    localparam int ST_ARRIVE_LSB = 0;
    localparam int ST_BADTAG     = 15;
    localparam int ST_OVF_LSB    = 16;
    localparam logic [3:0] Q_INVALID_TAG = 4'd15;

    typedef logic [12:0] len13_t;

    // Status bits that can ever be set; everything else stays 0.
    function automatic logic [31:0] status_valid_mask(input int nq);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < nq; i++) begin
            m[ST_ARRIVE_LSB + i] = 1'b1;
            m[ST_OVF_LSB + i]    = 1'b1;
        end
        m[ST_BADTAG] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/pcie_msg_queue_ctrl_ptr.sv
// rtl/pcie_msg_queue_ctrl_ptr.sv - per-queue write/read pointer pair with free-space check
module msg_queue_ptr
    import pcie_msg_pkg::*;
#(
    parameter int Q_DEPTH = 64,
    parameter int PTR_W   = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             msg_valid_i,
    input  logic [12:0]      msg_len_i,
    input  logic             rptr_wr_en_i,
    input  logic [PTR_W-1:0] rptr_wr_val_i,
    output logic [PTR_W-1:0] wptr_o,
    output logic [PTR_W-1:0] occ_o,
    output logic             accept_o
);

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] occ;
    logic [PTR_W-1:0] new_occ;
    len13_t           free_space;

    assign occ        = wptr_q - rptr_q;
    assign free_space = len13_t'(Q_DEPTH) - len13_t'(occ);
    assign accept_o   = (msg_len_i != '0) && (msg_len_i <= free_space);
    // A read-pointer move is judged against the wptr before any same-cycle message.
    assign new_occ    = wptr_q - rptr_wr_val_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (msg_valid_i && accept_o)
            wptr_d = wptr_q + msg_len_i[PTR_W-1:0];
        if (rptr_wr_en_i && (new_occ <= PTR_W'(Q_DEPTH)))
            rptr_d = rptr_wr_val_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    assign wptr_o = wptr_q;
    assign occ_o  = occ;

endmodule

// File: rtl/pcie_msg_queue_ctrl.sv
// rtl/pcie_msg_queue_ctrl.sv - per-queue write-pointer bookkeeping, W1C status and message interrupt
module pcie_msg_queue_ctrl
    import pcie_msg_pkg::*;
#(
    parameter int NUM_Q   = 15,
    parameter int Q_DEPTH = 64,
    parameter int PTR_W   = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             assembled_valid,
    input  logic [3:0]       assembled_tag,
    input  logic [11:0]      assembled_len,
    input  logic             rptr_wr_en,
    input  logic [3:0]       rptr_wr_q,
    input  logic [PTR_W-1:0] rptr_wr_val,
    input  logic [31:0]      q_intr_mask,
    input  logic [31:0]      q_intr_clear,
    input  logic [3:0]       q_sel,
    output logic [31:0]      q_intr_status,
    output logic [31:0]      q_data_wptr,
    output logic [PTR_W-1:0] q_occupancy,
    output logic [7:0]       drop_count,
    output logic             o_msg_interrupt
);

    localparam logic [31:0] ST_VALID = status_valid_mask(NUM_Q);
    localparam logic [3:0]  NUM_Q_4  = 4'(NUM_Q);

    logic [NUM_Q-1:0] msg_v;
    logic [NUM_Q-1:0] rptr_v;
    logic [NUM_Q-1:0] accept;
    logic [PTR_W-1:0] wptr_a [NUM_Q];
    logic [PTR_W-1:0] occ_a  [NUM_Q];
    len13_t           msg_len;

    logic [31:0]      status_q, status_d, set_vec;
    logic [7:0]       drop_q, drop_d;
    logic             bad_tag, drop_inc;
    logic             intr_q;
    logic [PTR_W-1:0] rb_wptr_q, rb_occ_q;

    assign msg_len = {1'b0, assembled_len};
    assign bad_tag = assembled_valid && (assembled_tag >= NUM_Q_4);

    for (genvar g = 0; g < NUM_Q; g++) begin : g_q
        assign msg_v[g]  = assembled_valid && (assembled_tag == 4'(g));
        assign rptr_v[g] = rptr_wr_en && (rptr_wr_q == 4'(g));

        msg_queue_ptr #(.Q_DEPTH(Q_DEPTH), .PTR_W(PTR_W)) u_ptr (
            .clk          (clk),
            .rst          (rst),
            .msg_valid_i  (msg_v[g]),
            .msg_len_i    (msg_len),
            .rptr_wr_en_i (rptr_v[g]),
            .rptr_wr_val_i(rptr_wr_val),
            .wptr_o       (wptr_a[g]),
            .occ_o        (occ_a[g]),
            .accept_o     (accept[g])
        );
    end

    always_comb begin
        set_vec = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            set_vec[ST_ARRIVE_LSB + i] = msg_v[i] & accept[i];
            set_vec[ST_OVF_LSB + i]    = msg_v[i] & ~accept[i];
        end
        set_vec[ST_BADTAG] = bad_tag;
        drop_inc = bad_tag | (|(msg_v & ~accept));
        // Set is OR-ed in after the clear so a coincident set wins.
        status_d = ((status_q & ~q_intr_clear) | set_vec) & ST_VALID;
        drop_d   = (drop_inc && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q  <= '0;
            drop_q    <= '0;
            intr_q    <= 1'b0;
            rb_wptr_q <= '0;
            rb_occ_q  <= '0;
        end else begin
            status_q  <= status_d;
            drop_q    <= drop_d;
            intr_q    <= |(status_q & q_intr_mask);
            rb_wptr_q <= (q_sel < NUM_Q_4) ? wptr_a[q_sel] : '0;
            rb_occ_q  <= (q_sel < NUM_Q_4) ? occ_a[q_sel]  : '0;
        end
    end

    assign q_intr_status   = status_q;
    assign q_data_wptr     = {16'h0, 9'h0, rb_wptr_q};
    assign q_occupancy     = rb_occ_q;
    assign drop_count      = drop_q;
    assign o_msg_interrupt = intr_q;

endmodule

// File: tb/tb_pcie_msg_queue_ctrl.sv
// tb/tb_pcie_msg_queue_ctrl.sv - self-checking bench for pcie_msg_queue_ctrl
module tb_pcie_msg_queue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        assembled_valid = 1'b0;
    logic [3:0]  assembled_tag = '0;
    logic [11:0] assembled_len = '0;
    logic        rptr_wr_en = 1'b0;
    logic [3:0]  rptr_wr_q = '0;
    logic [6:0]  rptr_wr_val = '0;
    logic [31:0] q_intr_mask = 32'hFFFF_FFFF;
    logic [31:0] q_intr_clear = '0;
    logic [3:0]  q_sel = '0;
    logic [31:0] q_intr_status;
    logic [31:0] q_data_wptr;
    logic [6:0]  q_occupancy;
    logic [7:0]  drop_count;
    logic        o_msg_interrupt;

    int checks = 0;
    int errors = 0;

    // Reference model: plain integer pointers per queue
    int          m_w [15];
    int          m_r [15];
    logic [31:0] m_status;
    int          m_drop;
    logic        m_int;
    int          m_rbw, m_rbo;

    always #5 clk = ~clk;

    pcie_msg_queue_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .assembled_valid(assembled_valid),
        .assembled_tag  (assembled_tag),
        .assembled_len  (assembled_len),
        .rptr_wr_en     (rptr_wr_en),
        .rptr_wr_q      (rptr_wr_q),
        .rptr_wr_val    (rptr_wr_val),
        .q_intr_mask    (q_intr_mask),
        .q_intr_clear   (q_intr_clear),
        .q_sel          (q_sel),
        .q_intr_status  (q_intr_status),
        .q_data_wptr    (q_data_wptr),
        .q_occupancy    (q_occupancy),
        .drop_count     (drop_count),
        .o_msg_interrupt(o_msg_interrupt)
    );

    task automatic model_clear();
        for (int i = 0; i < 15; i++) begin
            m_w[i] = 0;
            m_r[i] = 0;
        end
        m_status = '0;
        m_drop = 0;
        m_int = 1'b0;
        m_rbw = 0;
        m_rbo = 0;
    endtask

    // Advance one clock: evaluate the model on the current inputs, clock, then drop the pulses.
    task automatic tick();
        int ow [15];
        int orr [15];
        logic [31:0] setv;
        bit drop;
        int occ, t, q;
        setv = '0;
        drop = 0;
        for (int i = 0; i < 15; i++) begin
            ow[i] = m_w[i];
            orr[i] = m_r[i];
        end
        m_int = |(m_status & q_intr_mask);
        if (q_sel < 15) begin
            m_rbw = ow[q_sel];
            m_rbo = (ow[q_sel] - orr[q_sel] + 128) % 128;
        end else begin
            m_rbw = 0;
            m_rbo = 0;
        end
        if (assembled_valid) begin
            t = assembled_tag;
            if (t >= 15) begin
                setv[15] = 1'b1;
                drop = 1;
            end else begin
                occ = (ow[t] - orr[t] + 128) % 128;
                if (assembled_len == 0 || int'(assembled_len) > 64 - occ) begin
                    setv[16 + t] = 1'b1;
                    drop = 1;
                end else begin
                    m_w[t] = (ow[t] + int'(assembled_len)) % 128;
                    setv[t] = 1'b1;
                end
            end
        end
        if (rptr_wr_en && rptr_wr_q < 15) begin
            q = rptr_wr_q;
            if ((ow[q] - int'(rptr_wr_val) + 128) % 128 <= 64)
                m_r[q] = rptr_wr_val;
        end
        m_status = (m_status & ~q_intr_clear) | setv;
        if (drop && m_drop < 255)
            m_drop = m_drop + 1;
        @(posedge clk);
        #1;
        assembled_valid = 1'b0;
        rptr_wr_en = 1'b0;
        q_intr_clear = '0;
    endtask

    task automatic send(input int tag, input int len);
        assembled_valid = 1'b1;
        assembled_tag = 4'(tag);
        assembled_len = 12'(len);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_clear();
        checks++;
        if (q_intr_status !== 32'h0 || q_data_wptr !== 32'h0 || q_occupancy !== 7'h0 ||
            drop_count !== 8'h0 || o_msg_interrupt !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: status=%h wptr=%h occ=%h drop=%0d int=%b required all zero",
                     q_intr_status, q_data_wptr, q_occupancy, drop_count, o_msg_interrupt);
        end
        @(posedge clk);
        #1;
        assembled_valid = 1'b0;
        rptr_wr_en = 1'b0;
        q_intr_clear = '0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        q_sel = 4'd0;
        tick();
        checks++;
        if (q_intr_status !== 32'h0 || drop_count !== 8'h0 || q_data_wptr !== 32'h0) begin
            errors++;
            $display("FAIL reset_idle: status=%h drop=%0d wptr=%h required 0", q_intr_status, drop_count, q_data_wptr);
        end
    endtask

    task automatic test_arrive();
        do_reset();
        q_sel = 4'd2;
        send(2, 10);
        checks++;
        if (o_msg_interrupt !== 1'b0) begin
            errors++;
            $display("FAIL arrive_int_early: int=%b required 0", o_msg_interrupt);
        end
        send(2, 10);
        checks++;
        if (o_msg_interrupt !== 1'b1) begin
            errors++;
            $display("FAIL arrive_int_latency: int=%b required 1", o_msg_interrupt);
        end
        send(2, 10);
        tick();
        tick();
        checks++;
        if (q_data_wptr !== 32'd30 || q_intr_status !== 32'h0000_0004) begin
            errors++;
            $display("FAIL arrive_result: wptr=%0d status=%h required 30 00000004", q_data_wptr, q_intr_status);
        end
    endtask

    task automatic test_overflow_wrap();
        do_reset();
        q_sel = 4'd0;
        send(0, 60);
        send(0, 8);
        tick();
        checks++;
        if (q_data_wptr !== 32'd60 || q_intr_status[16] !== 1'b1 || drop_count !== 8'd1) begin
            errors++;
            $display("FAIL ovf_reject: wptr=%0d ovf=%b drop=%0d required 60 1 1", q_data_wptr, q_intr_status[16], drop_count);
        end
        rptr_wr_en = 1'b1;
        rptr_wr_q = 4'd0;
        rptr_wr_val = 7'd60;
        tick();
        send(0, 8);
        tick();
        tick();
        checks++;
        if (q_data_wptr !== 32'h44 || q_occupancy !== 7'd8) begin
            errors++;
            $display("FAIL ovf_wrap: wptr=%h occ=%0d required 44 8", q_data_wptr, q_occupancy);
        end
    endtask

    task automatic test_bad_tag();
        do_reset();
        q_sel = 4'd0;
        send(15, 4);
        checks++;
        if (q_intr_status !== 32'h0000_8000 || drop_count !== 8'd1 || o_msg_interrupt !== 1'b0) begin
            errors++;
            $display("FAIL badtag_set: status=%h drop=%0d int=%b required 00008000 1 0", q_intr_status, drop_count, o_msg_interrupt);
        end
        tick();
        checks++;
        if (o_msg_interrupt !== 1'b1 || q_data_wptr !== 32'h0) begin
            errors++;
            $display("FAIL badtag_int: int=%b wptr=%h required 1 0", o_msg_interrupt, q_data_wptr);
        end
        q_intr_clear = 32'h0000_8000;
        tick();
        checks++;
        if (q_intr_status !== 32'h0 || o_msg_interrupt !== 1'b1) begin
            errors++;
            $display("FAIL badtag_clear: status=%h int=%b required 0 1", q_intr_status, o_msg_interrupt);
        end
        tick();
        checks++;
        if (o_msg_interrupt !== 1'b0) begin
            errors++;
            $display("FAIL badtag_int_drop: int=%b required 0", o_msg_interrupt);
        end
    endtask

    task automatic test_set_clear();
        do_reset();
        send(3, 1);
        q_intr_clear = 32'h8;
        send(3, 1);
        checks++;
        if (q_intr_status !== 32'h8) begin
            errors++;
            $display("FAIL set_wins: status=%h required 00000008", q_intr_status);
        end
        q_intr_clear = 32'h8;
        tick();
        checks++;
        if (q_intr_status !== 32'h0) begin
            errors++;
            $display("FAIL clear_only: status=%h required 0", q_intr_status);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        q_sel = 4'd5;
        for (int i = 0; i < 70; i++)
            send(5, 1);
        tick();
        tick();
        checks++;
        if (q_occupancy !== 7'd64 || drop_count !== 8'd6 || q_data_wptr !== 32'd64) begin
            errors++;
            $display("FAIL b2b: occ=%0d drop=%0d wptr=%0d required 64 6 64", q_occupancy, drop_count, q_data_wptr);
        end
        checks++;
        if (q_intr_status !== 32'h0020_0020) begin
            errors++;
            $display("FAIL b2b_status: status=%h required 00200020", q_intr_status);
        end
    endtask

    task automatic test_reset_midburst();
        do_reset();
        q_sel = 4'd1;
        send(1, 3);
        send(2, 5);
        assembled_valid = 1'b1;
        assembled_tag = 4'd1;
        assembled_len = 12'd7;
        do_reset();
        send(1, 2);
        tick();
        tick();
        checks++;
        if (q_data_wptr !== 32'd2 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL midburst: wptr=%0d drop=%0d required 2 0", q_data_wptr, drop_count);
        end
    endtask

    task automatic test_random();
        int occ, q;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) != 0) begin
                assembled_valid = 1'b1;
                assembled_tag = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 7) == 0)
                    assembled_len = 12'($urandom_range(0, 4095));
                else
                    assembled_len = 12'($urandom_range(0, 12));
            end
            if ($urandom_range(0, 2) == 0) begin
                q = $urandom_range(0, 15);
                rptr_wr_en = 1'b1;
                rptr_wr_q = 4'(q);
                if (q < 15 && $urandom_range(0, 4) != 0) begin
                    occ = (m_w[q] - m_r[q] + 128) % 128;
                    rptr_wr_val = 7'((m_r[q] + $urandom_range(0, occ + 3)) % 128);
                end else
                    rptr_wr_val = 7'($urandom_range(0, 127));
            end
            if ($urandom_range(0, 4) == 0)
                q_intr_clear = $urandom;
            if ($urandom_range(0, 9) == 0)
                q_intr_mask = $urandom;
            q_sel = 4'($urandom_range(0, 15));
            tick();
            checks++;
            if (q_intr_status !== m_status || drop_count !== 8'(m_drop) || o_msg_interrupt !== m_int ||
                q_data_wptr !== 32'(m_rbw) || q_occupancy !== 7'(m_rbo)) begin
                errors++;
                $display("FAIL random[%0d]: status=%h/%h drop=%0d/%0d int=%b/%b wptr=%0d/%0d occ=%0d/%0d (actual/required)",
                         n, q_intr_status, m_status, drop_count, m_drop, o_msg_interrupt, m_int,
                         q_data_wptr, m_rbw, q_occupancy, m_rbo);
            end
        end
        q_intr_mask = 32'hFFFF_FFFF;
    endtask

    initial begin
        model_clear();
        #2;
        test_reset();
        test_arrive();
        test_overflow_wrap();
        test_bad_tag();
        test_set_clear();
        test_back_to_back();
        test_reset_midburst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
